// File: rtl/pllcfg_pkg.sv
// Shared constants for the PLL reconfiguration controller: state encoding,
// pll_cfg register map, counter words for both video standards, and the
// per-state write payload lookup.
package pllcfg_pkg;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STATE_W = 4;

    // Sequencer states
    localparam logic [STATE_W-1:0] IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] W_MODE    = 4'd1;
    localparam logic [STATE_W-1:0] W_N       = 4'd2;
    localparam logic [STATE_W-1:0] W_M       = 4'd3;
    localparam logic [STATE_W-1:0] W_C0      = 4'd4;
    localparam logic [STATE_W-1:0] W_FRAC    = 4'd5;
    localparam logic [STATE_W-1:0] W_START   = 4'd6;
    localparam logic [STATE_W-1:0] WAIT_LOCK = 4'd7;
    localparam logic [STATE_W-1:0] DONE      = 4'd8;

    // pll_cfg register map
    localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'd0;
    localparam logic [ADDR_W-1:0] ADDR_START = 6'd2;
    localparam logic [ADDR_W-1:0] ADDR_N     = 6'd3;
    localparam logic [ADDR_W-1:0] ADDR_M     = 6'd4;
    localparam logic [ADDR_W-1:0] ADDR_C0    = 6'd5;
    localparam logic [ADDR_W-1:0] ADDR_MFRAC = 6'd7;

    // Counter words; N and M are shared, C0 and fractional M select the standard
    localparam logic [DATA_W-1:0] N_CNT      = 32'h0001_0000;
    localparam logic [DATA_W-1:0] M_CNT      = 32'h0000_0404;
    localparam logic [DATA_W-1:0] C0_NTSC    = 32'h0000_0505;
    localparam logic [DATA_W-1:0] C0_PAL     = 32'h0002_0504;
    localparam logic [DATA_W-1:0] MFRAC_NTSC = 32'h9745_BF27;
    localparam logic [DATA_W-1:0] MFRAC_PAL  = 32'hA3D7_09E8;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } mgmt_wr_t;

    // Address/data issued by each write state for the given target standard
    function automatic mgmt_wr_t reg_write(input logic [STATE_W-1:0] state, input logic tgt);
        mgmt_wr_t wr;
        wr.address = ADDR_MODE;
        wr.data    = '0;
        case (state)
            W_N: begin
                wr.address = ADDR_N;
                wr.data    = N_CNT;
            end
            W_M: begin
                wr.address = ADDR_M;
                wr.data    = M_CNT;
            end
            W_C0: begin
                wr.address = ADDR_C0;
                wr.data    = tgt ? C0_PAL : C0_NTSC;
            end
            W_FRAC: begin
                wr.address = ADDR_MFRAC;
                wr.data    = tgt ? MFRAC_PAL : MFRAC_NTSC;
            end
            W_START: begin
                wr.address = ADDR_START;
                wr.data    = '0;
            end
            default: begin
                wr.address = ADDR_MODE;
                wr.data    = '0;
            end
        endcase
        return wr;
    endfunction

    // Successor of a write state once its write has been accepted
    function automatic logic [STATE_W-1:0] next_write_state(input logic [STATE_W-1:0] state);
        logic [STATE_W-1:0] nx;
        case (state)
            W_MODE:  nx = W_N;
            W_N:     nx = W_M;
            W_M:     nx = W_C0;
            W_C0:    nx = W_FRAC;
            W_FRAC:  nx = W_START;
            W_START: nx = WAIT_LOCK;
            default: nx = IDLE;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-low clear.
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: retunes clk_sys between NTSC and PAL through
// the pll_cfg management port whenever the requested standard changes, holding
// the core in tv_reset until the PLL has relocked and stayed stable.
// Runs on CLK_50M since clk_sys itself is being retuned.
// Optional build macro PLLCFG_DEBOUNCE_EN: require pal to be stable for 2**16
// cycles before a request is taken.
module pll_reconfig_ctrl
    import pllcfg_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 2**20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pal,
    input  logic              pll_locked,
    input  logic              mgmt_waitrequest,
    output logic              mgmt_write,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic [DATA_W-1:0] mgmt_writedata,
    output logic              tv_reset,
    output logic              busy,
    output logic              cur_pal,
    output logic              lock_err
);

    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);

    logic               pal_s;
    logic               lock_s;
    logic               req_c;
    mgmt_wr_t           wr_c;

    logic [STATE_W-1:0] state,      state_nx;
    logic               tgt,        tgt_nx;
    logic               cur_pal_nx;
    logic               lock_err_nx;
    logic               busy_nx;
    logic               tv_reset_nx;
    logic               write_nx;
    logic [ADDR_W-1:0]  address_nx;
    logic [DATA_W-1:0]  data_nx;
    logic [STB_W-1:0]   stable_cnt, stable_nx;
    logic [TMO_W-1:0]   tmo_cnt,    tmo_nx;

    sync2 u_pal_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pal),
        .q       (pal_s)
    );

    sync2 u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lock_s)
    );

`ifdef PLLCFG_DEBOUNCE_EN
    localparam int unsigned DEB_W = 16;

    logic [DEB_W-1:0] deb_cnt;
    logic             pal_q;

    // Count consecutive cycles pal_s has held its value; restart on any change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pal_q   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            pal_q <= pal_s;
            if (pal_s != pal_q) begin
                deb_cnt <= '0;
            end else if (deb_cnt != '1) begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign req_c = (pal_s != cur_pal) && (deb_cnt == '1);
`else
    assign req_c = (pal_s != cur_pal);
`endif

    assign wr_c = reg_write(state, tgt);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            tgt            <= 1'b0;
            cur_pal        <= 1'b0;
            lock_err       <= 1'b0;
            busy           <= 1'b0;
            tv_reset       <= 1'b0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            stable_cnt     <= '0;
            tmo_cnt        <= '0;
        end else begin
            state          <= state_nx;
            tgt            <= tgt_nx;
            cur_pal        <= cur_pal_nx;
            lock_err       <= lock_err_nx;
            busy           <= busy_nx;
            tv_reset       <= tv_reset_nx;
            mgmt_write     <= write_nx;
            mgmt_address   <= address_nx;
            mgmt_writedata <= data_nx;
            stable_cnt     <= stable_nx;
            tmo_cnt        <= tmo_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx    = state;
        tgt_nx      = tgt;
        cur_pal_nx  = cur_pal;
        lock_err_nx = lock_err;
        busy_nx     = busy;
        tv_reset_nx = tv_reset;
        write_nx    = mgmt_write;
        address_nx  = mgmt_address;
        data_nx     = mgmt_writedata;
        stable_nx   = '0;
        tmo_nx      = '0;

        case (state)
            IDLE: begin
                if (req_c) begin
                    tgt_nx      = pal_s;
                    lock_err_nx = 1'b0;
                    busy_nx     = 1'b1;
                    tv_reset_nx = 1'b1;
                    state_nx    = W_MODE;
                end
            end

            // Each write state spends one gap cycle with the strobe low, then
            // holds the strobe until pll_cfg accepts it
            W_MODE, W_N, W_M, W_C0, W_FRAC, W_START: begin
                if (!mgmt_write) begin
                    write_nx   = 1'b1;
                    address_nx = wr_c.address;
                    data_nx    = wr_c.data;
                end else if (!mgmt_waitrequest) begin
                    write_nx = 1'b0;
                    state_nx = next_write_state(state);
                end
            end

            WAIT_LOCK: begin
                stable_nx = lock_s ? stable_cnt + STB_W'(1) : '0;
                tmo_nx    = tmo_cnt + TMO_W'(1);
                if (lock_s && (stable_cnt == STB_W'(LOCK_STABLE - 1))) begin
                    state_nx = DONE;
                end else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    lock_err_nx = 1'b1;
                    state_nx    = DONE;
                end
            end

            DONE: begin
                cur_pal_nx  = tgt;
                tv_reset_nx = 1'b0;
                busy_nx     = 1'b0;
                state_nx    = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
